jtpang_objdma: RTL and testbench

JTPANG_OBJDMA -- requirements
Module: jtpang_objdma

---
 rtl/jtpang_pkg.sv | 15 +
 rtl/jtpang_objdma.sv | 161 ++++++++++++++++
 tb/tb_jtpang_objdma.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtpang_pkg.sv
// Shared definitions for the jtpang object-table DMA: state encoding and
// default table geometry.
package jtpang_pkg;

   localparam int OBJDMA_AW  = 9;
   localparam int OBJDMA_LEN = 512;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_COPY = 2'd2,
      ST_REL  = 2'd3
   } objdma_state_t;

endpackage

// File: rtl/jtpang_objdma.sv
// Object DMA: on a dma_go rising edge, takes the CPU bus and copies LEN bytes
// from the CPU object RAM into the video object buffer, then releases the bus.
module jtpang_objdma
   import jtpang_pkg::*;
#(
   parameter int AW  = OBJDMA_AW,
   parameter int LEN = OBJDMA_LEN
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          dma_go,
   input  logic          busak_n,
   output logic          busrq,
   output logic [AW-1:0] src_addr,
   input  logic [7:0]    src_data,
   output logic [AW-1:0] dst_addr,
   output logic [7:0]    dst_data,
   output logic          dst_we,
   output logic          busy
);

   localparam logic [AW:0] ZERO_C = {(AW+1){1'b0}};
   localparam logic [AW:0] ONE_C  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] LEN_C  = (AW+1)'(LEN);
   localparam logic [AW:0] LAST_C = (AW+1)'(LEN - 1);

   objdma_state_t state_q, state_d;
   logic          prev_q, prev_d;
   logic          pend_q, pend_d;
   logic [AW:0]   rc_q, rc_d;
   logic [AW:0]   wc_q, wc_d;
   logic          rd_q, rd_d;
   logic          busrq_q, busrq_d;
   logic          busy_q, busy_d;
   logic          trig_s;

   assign trig_s = cen & dma_go & ~prev_q;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         prev_q  <= 1'b0;
         pend_q  <= 1'b0;
         rc_q    <= ZERO_C;
         wc_q    <= ZERO_C;
         rd_q    <= 1'b0;
         busrq_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         pend_q  <= pend_d;
         rc_q    <= rc_d;
         wc_q    <= wc_d;
         rd_q    <= rd_d;
         busrq_q <= busrq_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state, counters and pending-trigger logic; everything advances on cen only
   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      pend_d  = pend_q;
      rc_d    = rc_q;
      wc_d    = wc_q;
      rd_d    = rd_q;
      busrq_d = busrq_q;
      busy_d  = busy_q;
      if (cen) begin
         prev_d = dma_go;
         if (trig_s && (state_q != ST_IDLE)) begin
            pend_d = 1'b1;
         end else begin
            pend_d = pend_q;
         end
         case (state_q)
            ST_IDLE: begin
               if (trig_s) begin
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_REQ: begin
               if (!busak_n) begin
                  state_d = ST_COPY;
                  rc_d    = ZERO_C;
                  wc_d    = ZERO_C;
                  rd_d    = 1'b0;
               end else begin
                  state_d = ST_REQ;
               end
            end
            ST_COPY: begin
               // A bus-ack loss freezes counters and the read-pending flag
               if (!busak_n) begin
                  if (rc_q < LEN_C) begin
                     rc_d = rc_q + ONE_C;
                     rd_d = 1'b1;
                  end else begin
                     rd_d = 1'b0;
                  end
                  if (rd_q) begin
                     wc_d = wc_q + ONE_C;
                     if (wc_q == LAST_C) begin
                        state_d = ST_REL;
                     end else begin
                        state_d = ST_COPY;
                     end
                  end else begin
                     wc_d = wc_q;
                  end
               end else begin
                  state_d = ST_COPY;
               end
            end
            ST_REL: begin
               if (busak_n) begin
                  if (pend_q || trig_s) begin
                     state_d = ST_REQ;
                     pend_d  = 1'b0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  state_d = ST_REL;
               end
            end
            default: state_d = ST_IDLE;
         endcase
         busrq_d = (state_d == ST_REQ) || (state_d == ST_COPY);
         busy_d  = (state_d != ST_IDLE);
      end else begin
         prev_d = prev_q;
      end
   end

   // Outputs; during a pause the pending read address is presented again so
   // that the RAM data is fresh when the write finally happens
   always_comb begin
      busrq    = busrq_q;
      busy     = busy_q;
      dst_we   = cen & ~busak_n & rd_q & (state_q == ST_COPY);
      dst_addr = wc_q[AW-1:0];
      if ((state_q == ST_COPY) && rd_q) begin
         dst_data = src_data;
      end else begin
         dst_data = 8'h00;
      end
      if ((state_q == ST_COPY) && busak_n && rd_q) begin
         src_addr = rc_q[AW-1:0] - AW'(1);
      end else begin
         src_addr = rc_q[AW-1:0];
      end
   end

endmodule

// File: tb/tb_jtpang_objdma.sv
// Self-checking bench for jtpang_objdma: scenario table plus random variants,
// a LEN=4 instance and a mid-transfer reset sequence.
module tb_jtpang_objdma;

   localparam int AW   = 9;
   localparam int LEN  = 512;
   localparam int LEN4 = 4;

   typedef struct {
      int ack_delay;
      int pause_wc;
      int pause_len;
      int n_trig;
      int exp_xfers;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cen = 1'b0;
   logic          dma_go = 1'b0, busak_n = 1'b1;
   logic          busrq, busy, dst_we;
   logic [AW-1:0] src_addr, dst_addr;
   logic [7:0]    src_data = 8'h00, dst_data;
   logic          dma_go4 = 1'b0, busak_n4 = 1'b1;
   logic          busrq4, busy4, dst_we4;
   logic [AW-1:0] src_addr4, dst_addr4;
   logic [7:0]    src_data4 = 8'h00, dst_data4;

   logic [7:0] ram [0:LEN-1];
   int wr_addr_q[$], wr_data_q[$], wr4_addr_q[$], wr4_data_q[$];
   int checks = 0, errors = 0;
   int bad_cen_we = 0, we_in_rst = 0;
   vec_t vecs [8];

   jtpang_objdma #(.AW(AW), .LEN(LEN)) dut (
      .clk(clk), .rst(rst), .cen(cen), .dma_go(dma_go), .busak_n(busak_n),
      .busrq(busrq), .src_addr(src_addr), .src_data(src_data),
      .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we), .busy(busy)
   );

   jtpang_objdma #(.AW(AW), .LEN(LEN4)) dut4 (
      .clk(clk), .rst(rst), .cen(cen), .dma_go(dma_go4), .busak_n(busak_n4),
      .busrq(busrq4), .src_addr(src_addr4), .src_data(src_data4),
      .dst_addr(dst_addr4), .dst_data(dst_data4), .dst_we(dst_we4), .busy(busy4)
   );

   always #5 clk = ~clk;

   // cen is high on every second rising edge
   always @(posedge clk) begin
      #1;
      cen = ~cen;
   end

   // CPU object RAM: data valid one cen cycle after the address
   always @(posedge clk) begin
      if (cen) begin
         src_data  <= ram[src_addr];
         src_data4 <= ram[src_addr4];
      end
   end

   // Write monitor
   always @(negedge clk) begin
      #2;
      if (dst_we) begin
         if (!cen) bad_cen_we++;
         if (rst) we_in_rst++;
         wr_addr_q.push_back(int'(dst_addr));
         wr_data_q.push_back(int'(dst_data));
      end
      if (dst_we4) begin
         if (!cen) bad_cen_we++;
         if (rst) we_in_rst++;
         wr4_addr_q.push_back(int'(dst_addr4));
         wr4_data_q.push_back(int'(dst_data4));
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Return at the negedge that precedes a cen rising edge
   task automatic step();
      do @(negedge clk); while (!cen);
   endtask

   // Every transfer is the byte sequence ram[0..LEN-1] written to 0..LEN-1
   task automatic check_writes(input string name, input int base, input int n_xfers);
      int n, bad;
      n = wr_addr_q.size() - base;
      bad = 0;
      check({name, "_wr_count"}, 32'(n), 32'(n_xfers * LEN));
      for (int i = 0; i < n; i++) begin
         if (wr_addr_q[base+i] != i % LEN || wr_data_q[base+i] != int'(ram[i % LEN])) bad++;
      end
      check({name, "_wr_order_data"}, 32'(bad), 32'd0);
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int  base, got, rises, grant_wait, pause_left, pause_bad, trig_idx;
      bit  prev_rq, granted, paused, hold_chk, done;
      base = wr_addr_q.size();
      rises = 0; grant_wait = 0; pause_left = 0; pause_bad = 0; trig_idx = 0;
      granted = 1'b0; paused = 1'b0; hold_chk = 1'b0; done = 1'b0;
      busak_n = 1'b1;
      step();
      check({name, "_idle_busrq"}, 32'(busrq), 32'd0);
      dma_go = 1'b1;
      step();
      dma_go = 1'b0;
      check({name, "_busrq_1cen"}, 32'(busrq), 32'd1);
      check({name, "_busy_set"}, 32'(busy), 32'd1);
      prev_rq = 1'b1;
      rises = 1;
      for (int c = 0; c < 4000 && !done; c++) begin
         got = wr_addr_q.size() - base;
         if (busrq && !prev_rq) rises++;
         prev_rq = busrq;
         if (got >= v.exp_xfers * LEN && !busy && !busrq) begin
            done = 1'b1;
         end else begin
            if (dma_go) begin
               dma_go = 1'b0;
            end else if (granted && trig_idx < v.n_trig && got >= 150 + 60 * trig_idx && got < LEN) begin
               dma_go = 1'b1;
               trig_idx++;
            end
            if (!paused && granted && busrq && got == v.pause_wc) begin
               paused = 1'b1;
               pause_left = v.pause_len;
            end
            if (pause_left > 0) begin
               if (!busrq) pause_bad++;
               busak_n = 1'b1;
               pause_left--;
               hold_chk = (pause_left == 0);
            end else begin
               if (hold_chk) begin
                  check({name, "_pause_nowr"}, 32'(got), 32'(v.pause_wc));
                  hold_chk = 1'b0;
               end
               if (busrq) begin
                  if (grant_wait >= v.ack_delay) begin
                     busak_n = 1'b0;
                     granted = 1'b1;
                  end else begin
                     grant_wait++;
                  end
               end else begin
                  busak_n = 1'b1;
                  grant_wait = 0;
                  granted = 1'b0;
               end
            end
            step();
         end
      end
      dma_go = 1'b0;
      check({name, "_done"}, 32'(done), 32'd1);
      check({name, "_busrq_rises"}, 32'(rises), 32'(v.exp_xfers));
      check({name, "_pause_busrq"}, 32'(pause_bad), 32'd0);
      check_writes(name, base, v.exp_xfers);
      busak_n = 1'b1;
      repeat (10) step();
      check({name, "_idle_busrq_end"}, 32'(busrq), 32'd0);
      check({name, "_idle_busy_end"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int  base, cnt, rises4, bad, got_r;
      bit  prev, reached;
      string nm;

      for (int i = 0; i < LEN; i++) ram[i] = 8'($urandom);
      //        ack pause_wc len trig xfers
      vecs[0] = '{3,  -1,      0,  0,   1};
      vecs[1] = '{3,  100,     5,  0,   1};
      vecs[2] = '{2,  -1,      0,  2,   2};
      vecs[3] = '{0,  0,       3,  0,   1};
      vecs[4] = '{1,  511,     2,  1,   2};
      for (int i = 5; i < 8; i++) begin
         vecs[i].ack_delay = int'($urandom_range(0, 4));
         vecs[i].pause_wc  = int'($urandom_range(0, LEN - 1));
         vecs[i].pause_len = int'($urandom_range(1, 6));
         vecs[i].n_trig    = int'($urandom_range(0, 3));
         vecs[i].exp_xfers = (vecs[i].n_trig > 0) ? 2 : 1;
      end

      repeat (3) @(negedge clk);
      #2;
      check("rst_busrq", 32'(busrq), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_dst_we", 32'(dst_we), 32'd0);
      check("rst_src_addr", 32'(src_addr), 32'd0);
      check("rst_dst_addr", 32'(dst_addr), 32'd0);
      check("rst_dst_data", 32'(dst_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         nm = $sformatf("vec%0d", i);
         run_vec(vecs[i], nm);
      end

      // LEN=4 with dma_go held high: one transfer, COPY lasts 5 cen cycles
      base = wr4_addr_q.size();
      cnt = 0; rises4 = 0; prev = 1'b0;
      step();
      dma_go4 = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (busrq4 && !prev) rises4++;
         prev = busrq4;
         busak_n4 = !busrq4;
         if (busrq4 && !busak_n4) cnt++;
      end
      check("len4_rises", 32'(rises4), 32'd1);
      check("len4_copy_cens", 32'(cnt - 1), 32'(LEN4 + 1));
      check("len4_wr_count", 32'(wr4_addr_q.size() - base), 32'(LEN4));
      bad = 0;
      for (int i = 0; i < wr4_addr_q.size() - base; i++) begin
         if (wr4_addr_q[base+i] != i || wr4_data_q[base+i] != int'(ram[i])) bad++;
      end
      check("len4_wr_order_data", 32'(bad), 32'd0);
      check("len4_busy_end", 32'(busy4), 32'd0);
      dma_go4 = 1'b0;
      busak_n4 = 1'b1;

      // Reset in the middle of a transfer, at wc=300
      base = wr_addr_q.size();
      reached = 1'b0;
      step();
      dma_go = 1'b1;
      step();
      dma_go = 1'b0;
      for (int c = 0; c < 2000 && !reached; c++) begin
         if (wr_addr_q.size() - base == 300) begin
            reached = 1'b1;
         end else begin
            busak_n = !busrq;
            step();
         end
      end
      check("rst_mid_reach300", 32'(reached), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_busrq", 32'(busrq), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_dst_we", 32'(dst_we), 32'd0);
      repeat (3) step();
      rst = 1'b0;
      got_r = wr_addr_q.size();
      repeat (10) step();
      check("rst_mid_no_wr_after", 32'(wr_addr_q.size()), 32'(got_r));
      check("rst_mid_busrq_after", 32'(busrq), 32'd0);
      busak_n = 1'b1;
      run_vec(vecs[0], "post_rst");

      check("we_outside_cen", 32'(bad_cen_we), 32'd0);
      check("we_during_rst", 32'(we_in_rst), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
